// File: rtl/frame_fetch_datapath_if.sv
// Bus bundle between the frame downloader FSM and its fetch datapath:
// the address-adder operands/result and the cache write/read ports.
interface frame_fetch_datapath_if #(
    parameter int WR_AW = 3
);
    logic [20:0]      add_a;
    logic [4:0]       add_b;
    logic             add_ce;
    logic [21:0]      add_sum;
    logic             wr_ce;
    logic [WR_AW-1:0] wr_addr;
    logic [31:0]      wr_data;
    logic             rd_ce;
    logic [WR_AW:0]   rd_addr;
    logic             rd_oce;
    logic [15:0]      rd_data;

    modport master (
        output add_a, add_b, add_ce,
        output wr_ce, wr_addr, wr_data,
        output rd_ce, rd_addr, rd_oce,
        input  add_sum, rd_data
    );

    modport slave (
        input  add_a, add_b, add_ce,
        input  wr_ce, wr_addr, wr_data,
        input  rd_ce, rd_addr, rd_oce,
        output add_sum, rd_data
    );
endinterface

// File: rtl/frame_fetch_datapath.sv
// Frame fetch datapath: a registered 21+5-bit address adder that advances
// the SDRAM read address, plus a small simple-dual-port cache that takes
// 32-bit memory words and returns 16-bit pixels (little-endian halfwords).
// READ_MODE=0 gives a 1-cycle read; READ_MODE=1 adds an output register
// gated by rd_oce for a 2-cycle read.
module frame_fetch_datapath #(
    parameter int WR_DEPTH  = 8,
    parameter int READ_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    frame_fetch_datapath_if.slave bus
);
    localparam int AW = $clog2(WR_DEPTH);

    // Cache storage is never reset; it powers up as all zeros.
    logic [31:0] r_mem [WR_DEPTH] = '{default: '0};

    logic [21:0] r_add_sum_p0;
    logic [15:0] r_rd_latch_p0;
    logic [31:0] w_rd_word;
    logic [15:0] w_rd_half;

    // Halfword address: upper bits pick the word, bit 0 picks the half.
    assign w_rd_word = r_mem[bus.rd_addr[AW:1]];
    assign w_rd_half = bus.rd_addr[0] ? w_rd_word[31:16] : w_rd_word[15:0];

    // ---- stage p0: adder register, full 22-bit sum keeps the carry-out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_add_sum_p0 <= '0;
        end else if (bus.add_ce) begin
            r_add_sum_p0 <= {1'b0, bus.add_a} + {17'b0, bus.add_b};
        end
    end

    // Cache write port; the read latch below samples the old word on a collision.
    always_ff @(posedge clk) begin
        if (bus.wr_ce) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // ---- stage p0: read latch captures the selected halfword
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_latch_p0 <= '0;
        end else if (bus.rd_ce) begin
            r_rd_latch_p0 <= w_rd_half;
        end
    end

    generate
        if (READ_MODE == 1) begin : g_pipe
            logic [15:0] r_rd_data_p1;

            // ---- stage p1: optional output register, advanced only by rd_oce
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rd_data_p1 <= '0;
                end else if (bus.rd_oce) begin
                    r_rd_data_p1 <= r_rd_latch_p0;
                end
            end

            assign bus.rd_data = r_rd_data_p1;
        end else begin : g_bypass
            // rd_oce has no effect in bypass mode.
            logic w_unused_oce;
            assign w_unused_oce = bus.rd_oce;
            assign bus.rd_data  = r_rd_latch_p0;
        end
    endgenerate

    assign bus.add_sum = r_add_sum_p0;
endmodule

// File: tb/tb_frame_fetch_datapath.sv
// Bench for frame_fetch_datapath: drives a bypass-mode and a pipeline-mode
// instance with identical stimulus and compares both against a halfword-view
// model of the cache and an arithmetic model of the adder on every cycle.
module tb_frame_fetch_datapath;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic [20:0] s_add_a = '0;
    logic [4:0]  s_add_b = '0;
    logic        s_add_ce = 1'b0;
    logic        s_wr_ce = 1'b0;
    logic [2:0]  s_wr_addr = '0;
    logic [31:0] s_wr_data = '0;
    logic        s_rd_ce = 1'b0;
    logic [3:0]  s_rd_addr = '0;
    logic        s_rd_oce = 1'b0;

    frame_fetch_datapath_if #(.WR_AW(3)) if0 ();
    frame_fetch_datapath_if #(.WR_AW(3)) if1 ();

    assign if0.add_a = s_add_a;     assign if1.add_a = s_add_a;
    assign if0.add_b = s_add_b;     assign if1.add_b = s_add_b;
    assign if0.add_ce = s_add_ce;   assign if1.add_ce = s_add_ce;
    assign if0.wr_ce = s_wr_ce;     assign if1.wr_ce = s_wr_ce;
    assign if0.wr_addr = s_wr_addr; assign if1.wr_addr = s_wr_addr;
    assign if0.wr_data = s_wr_data; assign if1.wr_data = s_wr_data;
    assign if0.rd_ce = s_rd_ce;     assign if1.rd_ce = s_rd_ce;
    assign if0.rd_addr = s_rd_addr; assign if1.rd_addr = s_rd_addr;
    assign if0.rd_oce = s_rd_oce;   assign if1.rd_oce = s_rd_oce;

    frame_fetch_datapath #(.WR_DEPTH(8), .READ_MODE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave));
    frame_fetch_datapath #(.WR_DEPTH(8), .READ_MODE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave));

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory as 8 words read through a 16-entry halfword view.
    logic [31:0] m_mem [8] = '{default: '0};
    logic [21:0] m_sum = '0;
    logic [15:0] m_latch = '0;
    logic [15:0] m_out1 = '0;

    function automatic logic [15:0] half(input int k);
        logic [31:0] w;
        w = m_mem[k / 2];
        return (k % 2 == 1) ? w[31:16] : w[15:0];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sum = '0;
            m_latch = '0;
            m_out1 = '0;
        end else begin
            if (s_rd_oce) m_out1 = m_latch;
            if (s_rd_ce) m_latch = half(int'(s_rd_addr));
            if (s_wr_ce) m_mem[s_wr_addr] = s_wr_data;
            if (s_add_ce) m_sum = 22'(s_add_a) + 22'(s_add_b);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_sum0", 32'(if0.add_sum), 32'(m_sum));
            check("cyc_sum1", 32'(if1.add_sum), 32'(m_sum));
            check("cyc_rd0", 32'(if0.rd_data), 32'(m_latch));
            check("cyc_rd1", 32'(if1.rd_data), 32'(m_out1));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [15:0] tbl [4] = '{16'hAAAA, 16'hBBBB, 16'hAAAB, 16'hBBBB};

    initial begin
        // Reset
        #1 reset_n = 1'b0;
        #1;
        check("rst_sum0", 32'(if0.add_sum), 32'h0);
        check("rst_rd0", 32'(if0.rd_data), 32'h0);
        check("rst_rd1", 32'(if1.rd_data), 32'h0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        step();

        // Adder basic and hold
        s_add_a = 21'h000100; s_add_b = 5'h10; s_add_ce = 1'b1;
        step();
        check("add_basic", 32'(if0.add_sum), 32'h000110);
        s_add_ce = 1'b0; s_add_a = 21'h0ABCDE; s_add_b = 5'h07;
        step();
        check("add_hold", 32'(if0.add_sum), 32'h000110);

        // Adder carry-out, then async reset between edges
        s_add_a = 21'h1FFFFF; s_add_b = 5'h1F; s_add_ce = 1'b1;
        step();
        check("add_max", 32'(if0.add_sum), 32'h20001E);
        check("add_max1", 32'(if1.add_sum), 32'h20001E);
        s_add_ce = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("add_async_rst", 32'(if0.add_sum), 32'h0);
        step();
        #2 reset_n = 1'b1;
        step();

        // Fill cache, then read all 16 halfwords
        s_rd_oce = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_wr_ce = 1'b1; s_wr_addr = 3'(k); s_wr_data = 32'hBBBBAAAA + 32'(k);
            step();
        end
        s_wr_ce = 1'b0;
        for (int k = 0; k < 16; k++) begin
            s_rd_ce = 1'b1; s_rd_addr = 4'(k);
            step();
            if (k < 4) check($sformatf("rd_seq%0d", k), 32'(if0.rd_data), 32'(tbl[k]));
            if (k >= 1 && k < 4) check($sformatf("rd_pipe%0d", k), 32'(if1.rd_data), 32'(tbl[k-1]));
        end
        check("rd_last", 32'(if0.rd_data), 32'h0000BBBB);
        s_rd_ce = 1'b0;

        // Read-before-write collision on word 2
        s_wr_ce = 1'b1; s_wr_addr = 3'd2; s_wr_data = 32'h0;
        step();
        s_wr_data = 32'h12345678; s_rd_ce = 1'b1; s_rd_addr = 4'd4;
        step();
        check("coll_old", 32'(if0.rd_data), 32'h0);
        s_wr_ce = 1'b0; s_rd_addr = 4'd4;
        step();
        check("coll_lo", 32'(if0.rd_data), 32'h5678);
        s_rd_addr = 4'd5;
        step();
        check("coll_hi", 32'(if0.rd_data), 32'h1234);

        // Pipeline mode latency and rd_oce hold
        s_rd_addr = 4'd0;
        step();
        s_rd_addr = 4'd5;
        step();
        check("pipe_prev", 32'(if1.rd_data), 32'hAAAA);
        s_rd_ce = 1'b0;
        step();
        check("pipe_2cyc", 32'(if1.rd_data), 32'h1234);
        s_rd_oce = 1'b0; s_rd_ce = 1'b1; s_rd_addr = 4'd1;
        step();
        s_rd_ce = 1'b0;
        step();
        check("pipe_hold", 32'(if1.rd_data), 32'h1234);
        check("pipe_hold_bypass", 32'(if0.rd_data), 32'hBBBB);
        s_rd_oce = 1'b1;
        step();
        check("pipe_release", 32'(if1.rd_data), 32'hBBBB);

        // Mid-stream reset; memory survives
        s_wr_ce = 1'b1; s_wr_addr = 3'd6; s_wr_data = 32'hCAFEF00D;
        step();
        s_wr_ce = 1'b0;
        s_add_a = 21'd5; s_add_b = 5'd3; s_add_ce = 1'b1;
        s_rd_ce = 1'b1; s_rd_addr = 4'd12;
        step();
        s_add_ce = 1'b0; s_rd_ce = 1'b0;
        check("pre_rst_sum", 32'(if0.add_sum), 32'd8);
        check("pre_rst_rd", 32'(if0.rd_data), 32'hF00D);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(if0.add_sum), 32'h0);
        check("mid_rst_rd0", 32'(if0.rd_data), 32'h0);
        check("mid_rst_rd1", 32'(if1.rd_data), 32'h0);
        step();
        #2 reset_n = 1'b1;
        step();
        s_rd_ce = 1'b1; s_rd_addr = 4'd12;
        step();
        check("post_rst12", 32'(if0.rd_data), 32'hF00D);
        s_rd_addr = 4'd13;
        step();
        check("post_rst13", 32'(if0.rd_data), 32'hCAFE);
        check("post_rst13_pipe", 32'(if1.rd_data), 32'hF00D);
        s_rd_addr = 4'd5;
        step();
        check("post_rst5", 32'(if0.rd_data), 32'h1234);
        s_rd_ce = 1'b0;
        step();
        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
